// File: rtl/fifo_out_stage_pkg.sv
// Shared types for the FIFO drain stage: buffer-occupancy states and perf counter width.
package fifo_out_stage_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} out_state_t;

  localparam int PERF_CW_DEFAULT = 32;

endpackage

// File: rtl/fifo_out_perf.sv
// Saturating stall/starve cycle counters; 1-cycle update, cleared by flush, no backpressure.
module fifo_out_perf
  import fifo_out_stage_pkg::*;
#(
  parameter int PERF_CW = PERF_CW_DEFAULT
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               flush,
  input  logic               stall_inc,
  input  logic               starve_inc,
  output logic [PERF_CW-1:0] stall_cnt,
  output logic [PERF_CW-1:0] starve_cnt
);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if (flush) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (starve_inc && !(&starve_cnt))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_out_stage.sv
// FIFO drain stage: 2-entry registered output buffer, FIFO entry to out_valid in 1 cycle, full rate.
// Backpressure stops popping only when both entries are held; fifo_pop never depends on out_ready. Perf counters under FIFO_OUT_STAGE_PERF_EN.
module fifo_out_stage
  import fifo_out_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PERF_CW = PERF_CW_DEFAULT
) (
  input  logic               clock,
  input  logic               rstn,
  input  logic               fifo_valid,
  input  logic [WIDTH-1:0]   fifo_data,
  output logic               fifo_pop,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [PERF_CW-1:0] stall_cnt,
  output logic [PERF_CW-1:0] starve_cnt
);

  out_state_t       state, state_nxt;
  logic [WIDTH-1:0] skid;
  logic             acc, enq;

  // Gated by rstn so no entry is pulled out of the FIFO while this stage is held in reset.
  assign fifo_pop = rstn && fifo_valid && !flush && (state != TWO);
  assign enq      = fifo_pop;
  assign acc      = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (enq) state_nxt = ONE;
        ONE: begin
          if (enq && !acc)      state_nxt = TWO;
          else if (!enq && acc) state_nxt = EMPTY;
        end
        TWO:     if (acc) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // fifo_data is only sampled under enq; out_data is left alone on flush.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
      skid     <= '0;
    end else begin
      case (state)
        EMPTY: if (enq) out_data <= fifo_data;
        ONE: begin
          if (enq && acc) out_data <= fifo_data;
          else if (enq)   skid     <= fifo_data;
        end
        TWO:     if (acc) out_data <= skid;
        default: ;
      endcase
    end
  end

`ifdef FIFO_OUT_STAGE_PERF_EN
  fifo_out_perf #(
    .PERF_CW (PERF_CW)
  ) u_perf (
    .clock      (clock),
    .rstn       (rstn),
    .flush      (flush),
    .stall_inc  (out_valid && !out_ready),
    .starve_inc (!out_valid && !fifo_valid),
    .stall_cnt  (stall_cnt),
    .starve_cnt (starve_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign starve_cnt = '0;
`endif

endmodule

// File: doc/fifo_out_stage.md
Name: fifo_out_stage

Overview:
- Downstream drain stage for the synchronous FIFO.
- Pops the FIFO through its pop/valid interface, where data_out is valid only in the cycle pop && valid.
- Re-presents entries on a registered valid/ready stream to AFU consumers.
- A 2-entry output buffer keeps full throughput and cuts any combinational path from out_ready to fifo_pop.

Parameters:
- WIDTH, 32, data width; must match the upstream FIFO WIDTH.
- PERF_CW, 32, width of the performance counters (used only with the optional feature).

Ports:
- clock  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- fifo_valid  input  1  FIFO valid (!empty).
- fifo_data  input  WIDTH  FIFO data_out; meaningful only in a cycle where fifo_pop is high.
- fifo_pop  output  1  FIFO pop request.
- flush  input  1  synchronous discard of buffered entries.
- out_valid  output  1  output entry valid.
- out_data  output  WIDTH  output entry data.
- out_ready  input  1  consumer accepts the entry.
- stall_cnt  output  PERF_CW  cycles with out_valid && !out_ready.
- starve_cnt  output  PERF_CW  cycles with !out_valid && !fifo_valid.

Behaviour:
- Reset: state EMPTY; out_valid=0, out_data=0, fifo_pop=0 (combinational from state), skid register=0, counters=0.
- Reset mid-operation discards all buffered entries immediately.
- State machine tracks buffer occupancy: EMPTY (0), ONE (1), TWO (2).
- fifo_pop = fifo_valid && !flush && (state != TWO).
  - fifo_pop is a function of registered state and FIFO/flush inputs only; it never depends on out_ready.
- fifo_data is captured in the same cycle fifo_pop is high; no other cycle samples it.
- Accept: acc = out_valid && out_ready. Enqueue: enq = fifo_pop.
- EMPTY:
  - enq -> ONE; out_data <= fifo_data; out_valid=1 next cycle.
  - Latency: FIFO entry to out_valid is 1 cycle.
- ONE:
  - enq && acc -> ONE; out_data <= fifo_data.
  - enq && !acc -> TWO; skid <= fifo_data.
  - !enq && acc -> EMPTY.
  - Otherwise hold.
- TWO:
  - acc -> ONE; out_data <= skid.
  - No pop occurs in TWO.
- out_data and out_valid are registered.
- out_data is stable while out_valid && !out_ready (no change until accepted).
- Ordering: strict FIFO order is preserved; no entry is dropped or duplicated except by flush.
- Sustained throughput is 1 entry/cycle with out_ready held high (steady state ONE).
- The FIFO's zeroed data_out when not popped is never captured.
- flush:
  - A transfer in the flush cycle (acc) counts as completed.
  - All remaining entries are dropped; state -> EMPTY; out_valid=0 next cycle.
  - fifo_pop is 0 in the flush cycle.
  - out_data is not cleared; its value is don't-care while out_valid=0.
- The block does not observe FIFO empty/full beyond fifo_valid.
- fifo_pop while fifo_valid=0 is never issued.

Optional Feature:
- Macro: FIFO_OUT_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid && !out_ready.
  - starve_cnt increments each cycle !out_valid && !fifo_valid.
  - Both saturate at all-ones, reset to 0 on rstn, and clear on flush.
- Undefined: stall_cnt and starve_cnt are tied to 0; no counter flops are generated.

Decomposition:
- Package fifo_out_stage_pkg holds:
  - typedef enum logic [1:0] {EMPTY, ONE, TWO} out_state_t;
  - localparam PERF_CW_DEFAULT = 32.
- One sub-module: fifo_out_perf, the two saturating counters.
  - Instantiated only under FIFO_OUT_STAGE_PERF_EN.
  - Takes clock, rstn, flush and the two increment conditions.

Test Plan:
- Stream: FIFO holds 0x11..0x18 (8 entries), out_ready=1.
  - fifo_pop high 8 consecutive cycles.
  - out_valid high 8 consecutive cycles starting 1 cycle after the first pop.
  - out_data sequence 0x11..0x18.
- Backpressure:
  - out_ready=0 after the first entry -> exactly one more pop (state TWO), then fifo_pop=0.
  - out_data holds 0x11.
  - Raising out_ready delivers 0x11, 0x12, 0x13 in order with no gap and no loss.
- Sparse source: single entry 0xA5, then FIFO empty with out_ready=0 for 5 cycles.
  - out_valid=1 and out_data=0xA5 held for all 5 cycles.
  - Accepted on the first out_ready; out_valid=0 the next cycle.
- Flush in TWO with out_ready=1:
  - The head entry transfers; the skid entry is discarded.
  - out_valid=0 next cycle; fifo_pop=0 during the flush cycle.
  - The next FIFO entry is the next output.
- Async reset asserted in TWO mid-stream:
  - out_valid=0, fifo_pop=0 and out_data=0 immediately.
  - After release, resumes from state EMPTY.
- PERF_EN: out_ready=0 for 10 cycles with out_valid=1 -> stall_cnt=10.
  - FIFO empty and buffer empty for 4 cycles -> starve_cnt=4.
  - flush -> both counters read 0.
